vga_timing_gen: RTL and testbench

//  640x480@60 Hz VGA raster timing generator that feeds the pixel bit generator.
//  - Divides the system clock down to a pixel-enable strobe.
//  - Runs the horizontal/vertical counters and decodes hSync, vSync and bright.
//  - Emits line/frame tick pulses for game logic (player x/y update, level advance).

---
 rtl/vga_timing_gen.sv | 124 ++++++++++++
 tb/tb_vga_timing_gen.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 Hz VGA raster timing generator.
// Divides clk down to a pixel strobe, runs the horizontal/vertical counters,
// decodes hSync/vSync/bright and emits line/frame ticks for game logic.
// Optional feature macro: VGA_FRAME_COUNT_EN adds a free-running 16-bit frameCount output.
module vga_timing_gen #(
    parameter int CLK_DIV = 2,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int H_VIS   = 640,
    parameter int H_FP    = 16,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33,
    parameter int V_VIS   = 480,
    parameter int V_FP    = 10
) (
    input  logic       clk,
    input  logic       reset,
    output logic       pixEn,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       hSync,
    output logic       vSync,
    output logic       bright,
    output logic       lineTick,
    output logic       frameTick
`ifdef VGA_FRAME_COUNT_EN
    ,
    output logic [15:0] frameCount
`endif
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_VIS + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_VIS + V_FP;

    // Count 0 is the start of sync, so the visible window sits after sync + back porch.
    localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_END  = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_END  = 10'(V_SYNC);
    localparam logic [9:0] H_VIS_START = 10'(H_SYNC + H_BP);
    localparam logic [9:0] H_VIS_END   = 10'(H_SYNC + H_BP + H_VIS);
    localparam logic [9:0] V_VIS_START = 10'(V_SYNC + V_BP);
    localparam logic [9:0] V_VIS_END   = 10'(V_SYNC + V_BP + V_VIS);

    // CLK_DIV is 1..16, so the divider fits in 4 bits; CLK_DIV=1 parks it at 0.
    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

    logic [3:0] div_cnt;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       pix_en;
    logic       h_wrap;
    logic       v_wrap;

    assign pix_en = (div_cnt == DIV_LAST);
    assign h_wrap = (h_cnt == H_LAST);
    assign v_wrap = (v_cnt == V_LAST);

    // Pixel-rate divider: strobes on its last count, then restarts at 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= 4'd0;
        end else if (pix_en) begin
            div_cnt <= 4'd0;
        end else begin
            div_cnt <= div_cnt + 4'd1;
        end
    end

    // Horizontal counter advances only on the pixel strobe and wraps at the end of the line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt <= 10'd0;
        end else if (pix_en) begin
            if (h_wrap) begin
                h_cnt <= 10'd0;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    // Vertical counter steps once per line and wraps together with the last pixel of the frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_cnt <= 10'd0;
        end else if (pix_en && h_wrap) begin
            if (v_wrap) begin
                v_cnt <= 10'd0;
            end else begin
                v_cnt <= v_cnt + 10'd1;
            end
        end
    end

    // Decodes come straight off the registered counters so they line up with hCount/vCount.
    always_comb begin
        pixEn     = pix_en;
        hCount    = h_cnt;
        vCount    = v_cnt;
        hSync     = !(h_cnt < H_SYNC_END);
        vSync     = !(v_cnt < V_SYNC_END);
        bright    = (h_cnt >= H_VIS_START) && (h_cnt < H_VIS_END) &&
                    (v_cnt >= V_VIS_START) && (v_cnt < V_VIS_END);
        lineTick  = pix_en && h_wrap;
        frameTick = pix_en && h_wrap && v_wrap;
    end

`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] frame_count_q;

    // Frame counter for game logic; wraps naturally from 16'hFFFF to 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_count_q <= 16'd0;
        end else if (frameTick) begin
            frame_count_q <= frame_count_q + 16'd1;
        end
    end

    assign frameCount = frame_count_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen.
// dut_a uses the full 640x480 geometry (line-level timing, reset mid-frame);
// dut_s uses a tiny geometry so whole frames fit in a short run.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_a;
    logic reset_s;

    logic       pixEn_a, hSync_a, vSync_a, bright_a, lineTick_a, frameTick_a;
    logic [9:0] hCount_a, vCount_a;
    logic       pixEn_s, hSync_s, vSync_s, bright_s, lineTick_s, frameTick_s;
    logic [9:0] hCount_s, vCount_s;
`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] frameCount_a, frameCount_s;
`endif

    vga_timing_gen dut_a (
        .clk(clk), .reset(reset_a), .pixEn(pixEn_a), .hCount(hCount_a), .vCount(vCount_a),
        .hSync(hSync_a), .vSync(vSync_a), .bright(bright_a),
        .lineTick(lineTick_a), .frameTick(frameTick_a)
`ifdef VGA_FRAME_COUNT_EN
        , .frameCount(frameCount_a)
`endif
    );

    // Small geometry: H_TOTAL=17 (visible h 7..14), V_TOTAL=10 (visible v 4..8), 3 clks/pixel.
    vga_timing_gen #(
        .CLK_DIV(3), .H_SYNC(4), .H_BP(3), .H_VIS(8), .H_FP(2),
        .V_SYNC(2), .V_BP(2), .V_VIS(5), .V_FP(1)
    ) dut_s (
        .clk(clk), .reset(reset_s), .pixEn(pixEn_s), .hCount(hCount_s), .vCount(vCount_s),
        .hSync(hSync_s), .vSync(vSync_s), .bright(bright_s),
        .lineTick(lineTick_s), .frameTick(frameTick_s)
`ifdef VGA_FRAME_COUNT_EN
        , .frameCount(frameCount_s)
`endif
    );

    // Clocks since reset release; cyc==c is sampled after c rising edges.
    int cyc_a;
    int cyc_s;
    always @(posedge clk or posedge reset_a) begin
        if (reset_a) cyc_a <= 0;
        else         cyc_a <= cyc_a + 1;
    end
    always @(posedge clk or posedge reset_s) begin
        if (reset_s) cyc_s <= 0;
        else         cyc_s <= cyc_s + 1;
    end

    typedef struct {
        int cyc;
        int v;
        bit frame;
    } tick_t;

    tick_t qa[$];
    tick_t qs[$];

    int n_checks = 0;
    int n_errors = 0;

    int hs_low_a = 0, vs_low_a = 0, br_a = 0, first_h_a = -1, first_v_a = -1;
    int hs_low_s = 0, vs_low_s = 0, br_s = 0, first_h_s = -1, first_v_s = -1;
    int last_h_s = -1, last_v_s = -1;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_a(input int target);
        int n = 0;
        while (cyc_a < target && n < 100000) begin
            @(negedge clk);
            n++;
        end
        if (cyc_a < target) check("wait_a_timeout", cyc_a, target);
    endtask

    task automatic wait_s(input int target);
        int n = 0;
        while (cyc_s < target && n < 100000) begin
            @(negedge clk);
            n++;
        end
        if (cyc_s < target) check("wait_s_timeout", cyc_s, target);
    endtask

    // Monitor: pops the scoreboard on every lineTick and gathers per-window statistics.
    task automatic monitor();
        tick_t t;
        forever begin
            @(negedge clk);
            if (!reset_a) begin
                if (lineTick_a) begin
                    if (qa.size() == 0) begin
                        check("a_unexpected_linetick", qa.size(), 1);
                    end else begin
                        t = qa.pop_front();
                        check("a_tick_cyc", cyc_a, t.cyc);
                        check("a_tick_v", vCount_a, t.v);
                        check("a_tick_h", hCount_a, 799);
                        check("a_frametick", frameTick_a, t.frame);
                    end
                end else if (frameTick_a) begin
                    check("a_frametick_alone", frameTick_a, 0);
                end
                if (cyc_a >= 1600 && cyc_a < 3200) begin
                    if (!hSync_a) hs_low_a++;
                    if (!vSync_a) vs_low_a++;
                end
                if (cyc_a >= 56000 && cyc_a < 57600 && bright_a) br_a++;
                if (bright_a && first_h_a < 0) begin
                    first_h_a = int'(hCount_a);
                    first_v_a = int'(vCount_a);
                end
            end
            if (!reset_s) begin
                if (lineTick_s) begin
                    if (qs.size() == 0) begin
                        check("s_unexpected_linetick", qs.size(), 1);
                    end else begin
                        t = qs.pop_front();
                        check("s_tick_cyc", cyc_s, t.cyc);
                        check("s_tick_v", vCount_s, t.v);
                        check("s_tick_h", hCount_s, 16);
                        check("s_frametick", frameTick_s, t.frame);
                    end
                end else if (frameTick_s) begin
                    check("s_frametick_alone", frameTick_s, 0);
                end
                if (cyc_s < 510) begin
                    if (cyc_s < 51 && !hSync_s) hs_low_s++;
                    if (!vSync_s) vs_low_s++;
                    if (bright_s) begin
                        br_s++;
                        if (first_h_s < 0) begin
                            first_h_s = int'(hCount_s);
                            first_v_s = int'(vCount_s);
                        end
                        last_h_s = int'(hCount_s);
                        last_v_s = int'(vCount_s);
                    end
                end
            end
        end
    endtask

    initial begin
        int n;
        bit found;
        reset_a = 1'b1;
        reset_s = 1'b1;
        fork
            monitor();
        join_none

        // Reset held for 3 clocks: everything decodes to 0.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_a_pixen", pixEn_a, 0);
        check("rst_a_hcount", hCount_a, 0);
        check("rst_a_vcount", vCount_a, 0);
        check("rst_a_hsync", hSync_a, 0);
        check("rst_a_vsync", vSync_a, 0);
        check("rst_a_bright", bright_a, 0);
        check("rst_a_linetick", lineTick_a, 0);
        check("rst_a_frametick", frameTick_a, 0);
        check("rst_s_pixen", pixEn_s, 0);
        check("rst_s_hcount", hCount_s, 0);
        check("rst_s_vsync", vSync_s, 0);

        // Full geometry: line v ends at clk 1600*v+1599; line 36 is cut short by reset.
        for (int v = 0; v < 36; v++) qa.push_back('{cyc: 1600 * v + 1599, v: v, frame: 1'b0});
        // Small geometry: 51 clks/line, 510 clks/frame, last pixel of a line at +50.
        for (int f = 0; f < 3; f++)
            for (int l = 0; l < 10; l++)
                qs.push_back('{cyc: 510 * f + 51 * l + 50, v: l, frame: (l == 9)});

        @(posedge clk);
        #1;
        reset_a = 1'b0;
        reset_s = 1'b0;

        // First strobe follows one edge after release; hCount reaches 1 on the next.
        @(negedge clk);
        check("a_c0_pixen", pixEn_a, 0);
        @(negedge clk);
        check("a_c1_pixen", pixEn_a, 1);
        check("a_c1_hcount", hCount_a, 0);
        @(negedge clk);
        check("a_c2_pixen", pixEn_a, 0);
        check("a_c2_hcount", hCount_a, 1);

        wait_s(520);
        check("s_hsync_low_clks", hs_low_s, 12);
        check("s_vsync_low_clks", vs_low_s, 102);
        check("s_bright_clks", br_s, 120);
        check("s_first_bright_h", first_h_s, 7);
        check("s_first_bright_v", first_v_s, 4);
        check("s_last_bright_h", last_h_s, 14);
        check("s_last_bright_v", last_v_s, 8);
`ifdef VGA_FRAME_COUNT_EN
        check("s_framecount_1", frameCount_s, 1);
        wait_s(1030);
        check("s_framecount_2", frameCount_s, 2);
        force dut_s.frame_count_q = 16'hFFFF;
        @(negedge clk);
        release dut_s.frame_count_q;
        check("s_framecount_forced", frameCount_s, 16'hFFFF);
        wait_s(1535);
        check("s_framecount_wrap", frameCount_s, 0);
`else
        wait_s(1535);
`endif
        reset_s = 1'b1;

        wait_a(3200);
        check("a_hsync_low_clks", hs_low_a, 192);
        check("a_vsync_low_clks_line1", vs_low_a, 1600);

        found = 1'b0;
        n = 0;
        while (!found && n < 70000) begin
            @(negedge clk);
            n++;
            if (hCount_a == 10'd400 && vCount_a == 10'd36) found = 1'b1;
        end
        check("a_reached_400_36", found, 1);
        check("a_bright_clks_line35", br_a, 1280);
        check("a_first_bright_h", first_h_a, 144);
        check("a_first_bright_v", first_v_a, 35);
        check("a_bright_mid", bright_a, 1);

        // Mid-frame reset clears counters immediately, without a tick.
        #1;
        reset_a = 1'b1;
        #1;
        check("a_midrst_hcount", hCount_a, 0);
        check("a_midrst_vcount", vCount_a, 0);
        check("a_midrst_bright", bright_a, 0);
        check("a_midrst_hsync", hSync_a, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("a_midrst_linetick", lineTick_a, 0);
            check("a_midrst_frametick", frameTick_a, 0);
            check("a_midrst_pixen", pixEn_a, 0);
        end
        check("a_queue_drained_before_restart", qa.size(), 0);
        qa.push_back('{cyc: 1599, v: 0, frame: 1'b0});
        @(posedge clk);
        #1;
        reset_a = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("a_restart_c1_pixen", pixEn_a, 1);
        check("a_restart_c1_hcount", hCount_a, 0);
        wait_a(1601);
        check("a_restart_wrap_h", hCount_a, 0);
        check("a_restart_wrap_v", vCount_a, 1);

        check("a_queue_empty", qa.size(), 0);
        check("s_queue_empty", qs.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
